// File: rtl/data_mem_responder_if.sv
// MEM-stage data access bus between the pipeline (master) and the data memory responder (slave).
interface data_mem_responder_if #(
  parameter int LEN = 32
);
  logic           mem_read;
  logic           mem_write;
  logic [LEN-1:0] address;
  logic [LEN-1:0] write_data;
  logic [LEN-1:0] read_data;
  logic           ready;
  logic           freeze;
  logic           error;

  modport master (
    output mem_read, mem_write, address, write_data,
    input  read_data, ready, freeze, error
  );

  modport slave (
    input  mem_read, mem_write, address, write_data,
    output read_data, ready, freeze, error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: IDLE -> WAIT x LATENCY -> DONE, with a one-cycle ready pulse.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned addresses fault instead of being truncated.
module data_mem_responder #(
  parameter int LEN     = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2,
  parameter int BASE    = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN-1:0] BASE_W  = LEN'(BASE);
  localparam logic [LEN-1:0] DEPTH_W = LEN'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic           r_op_wr;
  logic [LEN-1:0] r_addr;
  logic [LEN-1:0] r_wdata;
  logic [LEN-1:0] r_rdata;
  logic           r_error;
  logic [LEN-1:0] r_mem [DEPTH];

  logic           w_req;
  logic           w_access;
  logic [LEN-1:0] w_offset;
  logic [LEN-1:0] w_index;
  logic [AW-1:0]  w_idx;
  logic           w_err;

  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);

  always_comb begin
    w_offset = r_addr - BASE_W;
    w_index  = w_offset >> 2;
    w_idx    = w_index[AW-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    w_err = (r_addr < BASE_W) || (w_index >= DEPTH_W) || (r_addr[1:0] != 2'b00);
`else
    w_err = (r_addr < BASE_W) || (w_index >= DEPTH_W);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready     = (r_state == S_DONE);
    bus.freeze    = w_req & (r_state != S_DONE) & ~reset;
    bus.read_data = r_rdata;
    bus.error     = r_error;
  end

  // Datapath: request latch, latency counter, and the single access at the WAIT->DONE edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_error <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_op_wr <= bus.mem_write;
        r_addr  <= bus.address;
        r_wdata <= bus.write_data;
        r_cnt   <= CW'(LATENCY - 1);
      end else if (r_state == S_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_error <= w_err;
        r_rdata <= w_err ? '0 : r_mem[w_idx];
        if (r_op_wr && !w_err) r_mem[w_idx] <= r_wdata;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (LEN=32, DEPTH=64, LATENCY=2, BASE=1024).
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.LEN(32)) bus ();

  data_mem_responder #(
    .LEN(32), .DEPTH(64), .LATENCY(2), .BASE(1024)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request from just after an edge, holds it through DONE, then drops it.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int fz, output int lat);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    fz = 0; lat = -1; rdata = 'x; err = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.freeze) fz++;
      if (bus.ready) begin
        rdata = bus.read_data;
        err   = bus.error;
        lat   = c;
        break;
      end
    end
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  logic [31:0] rdata;
  logic        err;
  int          fz, lat;
  int          seen;

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.address = '0; bus.write_data = '0;

    vecs.push_back('{"rd_base_init",  1'b1, 1'b0, 32'd1024, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"wr_1028",       1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"rd_1028",       1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"wr_below_base", 1'b0, 1'b1, 32'd1020, 32'h1,        32'h0,        1'b1});
    vecs.push_back('{"rd_past_end",   1'b1, 1'b0, 32'd1280, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"wr_1032",       1'b0, 1'b1, 32'd1032, 32'd5,        32'h0,        1'b0});
    vecs.push_back('{"rdwr_1032",     1'b1, 1'b1, 32'd1032, 32'd9,        32'd5,        1'b0});
    vecs.push_back('{"rd_1032",       1'b1, 1'b0, 32'd1032, 32'h0,        32'd9,        1'b0});
    vecs.push_back('{"wr_last_word",  1'b0, 1'b1, 32'd1276, 32'h77,       32'h0,        1'b0});
    vecs.push_back('{"rd_last_word",  1'b1, 1'b0, 32'd1276, 32'h0,        32'h77,       1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
    vecs.push_back('{"wr_misalign",   1'b0, 1'b1, 32'd1030, 32'h1234,     32'h0,        1'b1});
    vecs.push_back('{"rd_after_mis",  1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF, 1'b0});
`else
    vecs.push_back('{"wr_misalign",   1'b0, 1'b1, 32'd1030, 32'h1234,     32'hDEADBEEF, 1'b0});
    vecs.push_back('{"rd_after_mis",  1'b1, 1'b0, 32'd1028, 32'h0,        32'h1234,     1'b0});
`endif

    // Reset, then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {31'b0, bus.ready},  32'h0);
    chk("reset_freeze", {31'b0, bus.freeze}, 32'h0);
    chk("reset_error",  {31'b0, bus.error},  32'h0);
    chk("reset_rdata",  bus.read_data,       32'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err, fz, lat);
      chk({vecs[i].name, "_rdata"},  rdata,         vecs[i].exp_rdata);
      chk({vecs[i].name, "_error"},  {31'b0, err},  {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_latency"}, lat,          32'd3);
      chk({vecs[i].name, "_freeze"},  fz,           32'd3);
    end

    // Request dropped in cycle 1: transaction still completes, freeze follows the live request
    bus.mem_read = 1'b1; bus.address = 32'd1032;
    @(negedge clk);
    chk("drop_freeze_c0", {31'b0, bus.freeze}, 32'h1);
    @(posedge clk); #1;
    bus.mem_read = 1'b0;
    @(negedge clk);
    chk("drop_freeze_c1", {31'b0, bus.freeze}, 32'h0);
    chk("drop_ready_c1",  {31'b0, bus.ready},  32'h0);
    @(negedge clk);
    chk("drop_ready_c2",  {31'b0, bus.ready},  32'h0);
    @(negedge clk);
    chk("drop_ready_c3",  {31'b0, bus.ready},  32'h1);
    chk("drop_rdata_c3",  bus.read_data,       32'd9);
    @(posedge clk); #1;

    // Reset asserted during WAIT of a write: no ready pulse, word stays 0
    bus.mem_write = 1'b1; bus.address = 32'd1040; bus.write_data = 32'hAA;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gates_freeze", {31'b0, bus.freeze}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_write = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.ready) seen++;
    end
    chk("rst_no_ready", seen, 32'd0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1040, 32'h0, rdata, err, fz, lat);
    chk("rst_word_unchanged", rdata, 32'h0);
    chk("rst_word_latency",   lat,   32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
